// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host command link: framing byte, command codes,
// parser state encoding and payload-length lookup.
package uart_cmd_pkg;

    localparam logic [7:0] SOM                = 8'h55;
    localparam logic [7:0] CMD_TICS_PER_REV   = 8'h11;
    localparam logic [7:0] CMD_SET_SPEED1     = 8'h21;
    localparam logic [7:0] CMD_SET_SPEED2     = 8'h22;
    localparam logic [7:0] CMD_SET_ACCEL      = 8'h23;
    localparam logic [7:0] CMD_GET_ENCDR1     = 8'h24;
    localparam logic [7:0] CMD_GET_ENCDR2     = 8'h25;
    localparam logic [7:0] CMD_RST_ENCDRS     = 8'h26;

    localparam int unsigned LEN_W = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_HUNT = 2'd0;
    localparam state_t ST_CMD  = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_CHK  = 2'd3;

    function automatic logic cmd_known(input logic [7:0] cmd);
        case (cmd)
            CMD_TICS_PER_REV, CMD_SET_SPEED1, CMD_SET_SPEED2, CMD_SET_ACCEL,
            CMD_GET_ENCDR1, CMD_GET_ENCDR2, CMD_RST_ENCDRS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] payload_len(input logic [7:0] cmd);
        case (cmd)
            CMD_TICS_PER_REV:                              return LEN_W'(2);
            CMD_SET_SPEED1, CMD_SET_SPEED2, CMD_SET_ACCEL: return LEN_W'(1);
            default:                                       return LEN_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Received-byte stream from the uart_rx byte receiver into the command decoder.
interface uart_cmd_decoder_if;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;

    modport master (output i_Rx_DV, output i_Rx_Byte);
    modport slave  (input  i_Rx_DV, input  i_Rx_Byte);
endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout: reloads on clear, counts down while run is high,
// expired flags the terminal count.
module uart_rx_timeout #(
    parameter int unsigned c_TIMEOUT = 86800
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(c_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(c_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Host command frame parser: SOM, CMD, payload, XOR checksum. Valid frames
// update held motor registers and fire one-clock action strobes.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned c_CLKS_PER_BIT  = 1736,
    parameter int unsigned c_TIMEOUT_BYTES = 5
) (
    input  logic                clk_100MHz,
    input  logic                rst_n,
    uart_cmd_decoder_if.slave   rx,
    output logic [15:0]         o_tics_per_rev,
    output logic [7:0]          o_speed1,
    output logic [7:0]          o_speed2,
    output logic [7:0]          o_accel,
    output logic                o_get_enc1,
    output logic                o_get_enc2,
    output logic                o_rst_encdrs,
    output logic                o_cmd_valid,
    output logic                o_cmd_err
);
    localparam int unsigned c_TIMEOUT = c_TIMEOUT_BYTES * 10 * c_CLKS_PER_BIT;

    state_t             state, state_nx;
    logic [7:0]         cmd_q, cmd_nx;
    logic [LEN_W-1:0]   len_q, len_nx;
    logic [15:0]        hold_q, hold_nx;
    logic [7:0]         chk_q, chk_nx;
    logic [15:0]        tics_nx;
    logic [7:0]         speed1_nx, speed2_nx, accel_nx;
    logic               get_enc1_nx, get_enc2_nx, rst_encdrs_nx, valid_nx, err_nx;
    logic               tmo_expired_c;

    uart_rx_timeout #(.c_TIMEOUT(c_TIMEOUT)) u_timeout (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .clear      (rx.i_Rx_DV),
        .run        (state != ST_HUNT),
        .expired    (tmo_expired_c)
    );

    // Next-state, frame accumulation and commit decode
    always_comb begin
        state_nx      = state;
        cmd_nx        = cmd_q;
        len_nx        = len_q;
        hold_nx       = hold_q;
        chk_nx        = chk_q;
        tics_nx       = o_tics_per_rev;
        speed1_nx     = o_speed1;
        speed2_nx     = o_speed2;
        accel_nx      = o_accel;
        get_enc1_nx   = 1'b0;
        get_enc2_nx   = 1'b0;
        rst_encdrs_nx = 1'b0;
        valid_nx      = 1'b0;
        err_nx        = 1'b0;

        if (rx.i_Rx_DV) begin
            case (state)
                ST_HUNT: begin
                    if (rx.i_Rx_Byte == SOM) state_nx = ST_CMD;
                end
                ST_CMD: begin
                    if (cmd_known(rx.i_Rx_Byte)) begin
                        cmd_nx   = rx.i_Rx_Byte;
                        chk_nx   = rx.i_Rx_Byte;
                        len_nx   = payload_len(rx.i_Rx_Byte);
                        state_nx = (payload_len(rx.i_Rx_Byte) == '0) ? ST_CHK : ST_DATA;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = ST_HUNT;
                    end
                end
                ST_DATA: begin
                    hold_nx = {hold_q[7:0], rx.i_Rx_Byte};
                    chk_nx  = chk_q ^ rx.i_Rx_Byte;
                    len_nx  = len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) state_nx = ST_CHK;
                end
                default: begin
                    state_nx = ST_HUNT;
                    if (rx.i_Rx_Byte == chk_q) begin
                        valid_nx = 1'b1;
                        case (cmd_q)
                            CMD_TICS_PER_REV: tics_nx       = hold_q;
                            CMD_SET_SPEED1:   speed1_nx     = hold_q[7:0];
                            CMD_SET_SPEED2:   speed2_nx     = hold_q[7:0];
                            CMD_SET_ACCEL:    accel_nx      = hold_q[7:0];
                            CMD_GET_ENCDR1:   get_enc1_nx   = 1'b1;
                            CMD_GET_ENCDR2:   get_enc2_nx   = 1'b1;
                            CMD_RST_ENCDRS:   rst_encdrs_nx = 1'b1;
                            default:          valid_nx      = 1'b1;
                        endcase
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            endcase
        end else if (tmo_expired_c) begin
            // A byte landing on the terminal count takes the branch above instead
            err_nx   = 1'b1;
            state_nx = ST_HUNT;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_HUNT;
            cmd_q          <= 8'h00;
            len_q          <= '0;
            hold_q         <= 16'h0000;
            chk_q          <= 8'h00;
            o_tics_per_rev <= 16'h0000;
            o_speed1       <= 8'h80;
            o_speed2       <= 8'h80;
            o_accel        <= 8'h00;
            o_get_enc1     <= 1'b0;
            o_get_enc2     <= 1'b0;
            o_rst_encdrs   <= 1'b0;
            o_cmd_valid    <= 1'b0;
            o_cmd_err      <= 1'b0;
        end else begin
            state          <= state_nx;
            cmd_q          <= cmd_nx;
            len_q          <= len_nx;
            hold_q         <= hold_nx;
            chk_q          <= chk_nx;
            o_tics_per_rev <= tics_nx;
            o_speed1       <= speed1_nx;
            o_speed2       <= speed2_nx;
            o_accel        <= accel_nx;
            o_get_enc1     <= get_enc1_nx;
            o_get_enc2     <= get_enc2_nx;
            o_rst_encdrs   <= rst_encdrs_nx;
            o_cmd_valid    <= valid_nx;
            o_cmd_err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: frames, errors, timeout edge and reset.
module tb_uart_cmd_decoder;

    localparam int unsigned CLKS_PER_BIT  = 20;
    localparam int unsigned TIMEOUT_BYTES = 5;
    localparam int unsigned T_OUT         = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;

    logic        clk_100MHz;
    logic        rst_n;
    logic [15:0] o_tics_per_rev;
    logic [7:0]  o_speed1, o_speed2, o_accel;
    logic        o_get_enc1, o_get_enc2, o_rst_encdrs, o_cmd_valid, o_cmd_err;

    uart_cmd_decoder_if rx_if ();

    uart_cmd_decoder #(
        .c_CLKS_PER_BIT  (CLKS_PER_BIT),
        .c_TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clk_100MHz     (clk_100MHz),
        .rst_n          (rst_n),
        .rx             (rx_if.slave),
        .o_tics_per_rev (o_tics_per_rev),
        .o_speed1       (o_speed1),
        .o_speed2       (o_speed2),
        .o_accel        (o_accel),
        .o_get_enc1     (o_get_enc1),
        .o_get_enc2     (o_get_enc2),
        .o_rst_encdrs   (o_rst_encdrs),
        .o_cmd_valid    (o_cmd_valid),
        .o_cmd_err      (o_cmd_err)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    int n_valid = 0, n_err = 0, n_enc1 = 0, n_enc2 = 0, n_rst = 0;
    int s_valid = 0, s_err = 0, s_enc1 = 0, s_enc2 = 0, s_rst = 0;
    int n_tests = 0, n_fail = 0;

    // Pulse tallies, sampled mid-cycle
    always @(negedge clk_100MHz) begin
        if (o_cmd_valid)  n_valid++;
        if (o_cmd_err)    n_err++;
        if (o_get_enc1)   n_enc1++;
        if (o_get_enc2)   n_enc2++;
        if (o_rst_encdrs) n_rst++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_pulses(input string tag, input int ev, input int ee,
                                input int e1, input int e2, input int er);
        check({tag, ".valid"}, 32'(n_valid - s_valid), 32'(ev));
        check({tag, ".err"},   32'(n_err   - s_err),   32'(ee));
        check({tag, ".enc1"},  32'(n_enc1  - s_enc1),  32'(e1));
        check({tag, ".enc2"},  32'(n_enc2  - s_enc2),  32'(e2));
        check({tag, ".rst"},   32'(n_rst   - s_rst),   32'(er));
        s_valid = n_valid; s_err = n_err; s_enc1 = n_enc1; s_enc2 = n_enc2; s_rst = n_rst;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] tics,
                              input logic [7:0] sp1, input logic [7:0] sp2, input logic [7:0] acc);
        check({tag, ".tics"},   32'(o_tics_per_rev), 32'(tics));
        check({tag, ".speed1"}, 32'(o_speed1),       32'(sp1));
        check({tag, ".speed2"}, 32'(o_speed2),       32'(sp2));
        check({tag, ".accel"},  32'(o_accel),        32'(acc));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_100MHz);
        rx_if.i_Rx_DV   = 1'b1;
        rx_if.i_Rx_Byte = b;
        @(negedge clk_100MHz);
        rx_if.i_Rx_DV   = 1'b0;
        rx_if.i_Rx_Byte = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_100MHz);
    endtask

    initial begin
        rx_if.i_Rx_DV   = 1'b0;
        rx_if.i_Rx_Byte = 8'h00;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        check_regs("reset", 16'h0000, 8'h80, 8'h80, 8'h00);
        check("reset.strobes",
              32'({o_get_enc1, o_get_enc2, o_rst_encdrs, o_cmd_valid, o_cmd_err}), 32'h0);
        rst_n = 1'b1;
        settle();
        check_pulses("idle", 0, 0, 0, 0, 0);

        send_byte(8'h55); send_byte(8'h21); send_byte(8'hC0); send_byte(8'hE1);
        settle();
        check_regs("speed1", 16'h0000, 8'hC0, 8'h80, 8'h00);
        check_pulses("speed1", 1, 0, 0, 0, 0);

        send_byte(8'h55); send_byte(8'h11); send_byte(8'h05); send_byte(8'hA0); send_byte(8'hB4);
        settle();
        check_regs("tics", 16'h05A0, 8'hC0, 8'h80, 8'h00);
        check_pulses("tics", 1, 0, 0, 0, 0);

        send_byte(8'h55); send_byte(8'h22); send_byte(8'h10); send_byte(8'h00);
        settle();
        check_regs("badchk", 16'h05A0, 8'hC0, 8'h80, 8'h00);
        check_pulses("badchk", 0, 1, 0, 0, 0);
        send_byte(8'h55); send_byte(8'h26); send_byte(8'h26);
        settle();
        check_pulses("rstenc", 1, 0, 0, 0, 1);

        send_byte(8'h12); send_byte(8'h55); send_byte(8'h99);
        settle();
        check_pulses("unknown", 0, 1, 0, 0, 0);
        send_byte(8'h55); send_byte(8'h24); send_byte(8'h24);
        settle();
        check_pulses("getenc1", 1, 0, 1, 0, 0);

        // 0x55 as payload is ordinary data, not a resync
        send_byte(8'h55); send_byte(8'h21); send_byte(8'h55); send_byte(8'h74);
        settle();
        check_regs("som_data", 16'h05A0, 8'h55, 8'h80, 8'h00);
        check_pulses("som_data", 1, 0, 0, 0, 0);

        // Stall after CMD: error appears exactly T_OUT clocks after the last byte
        send_byte(8'h55); send_byte(8'h23);
        repeat (T_OUT - 1) @(negedge clk_100MHz);
        check("tmo.early", 32'(o_cmd_err), 32'h0);
        @(negedge clk_100MHz);
        check("tmo.edge", 32'(o_cmd_err), 32'h1);
        settle();
        check_regs("tmo", 16'h05A0, 8'h55, 8'h80, 8'h00);
        check_pulses("tmo", 0, 1, 0, 0, 0);

        // Payload byte sampled on the terminal-count cycle wins
        send_byte(8'h55); send_byte(8'h23);
        repeat (T_OUT - 2) @(negedge clk_100MHz);
        send_byte(8'h33);
        send_byte(8'h10);
        settle();
        check_regs("collide", 16'h05A0, 8'h55, 8'h80, 8'h33);
        check_pulses("collide", 1, 0, 0, 0, 0);

        send_byte(8'h55); send_byte(8'h11); send_byte(8'h05);
        @(negedge clk_100MHz);
        rst_n = 1'b0;
        @(negedge clk_100MHz);
        check_regs("midrst", 16'h0000, 8'h80, 8'h80, 8'h00);
        rst_n = 1'b1;
        settle();
        check_pulses("midrst", 0, 0, 0, 0, 0);
        send_byte(8'h55); send_byte(8'h25); send_byte(8'h25);
        settle();
        check_regs("getenc2", 16'h0000, 8'h80, 8'h80, 8'h00);
        check_pulses("getenc2", 1, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Parses the host command stream received over the UART link from the RP2040 and turns it into motor-controller register writes and action strobes. It is the inbound counterpart of the encoder debug frames sent on `uart_tx`. It sits between the `uart_rx` byte receiver and the motor/encoder blocks in `top`, on the 100 MHz domain. Validated frames update held registers. Malformed, unknown or stalled frames are dropped and flagged.

## Interface
Parameters:
- `c_CLKS_PER_BIT`, 1736: UART bit period in clocks (57600 baud); used only to size the timeout.
- `c_TIMEOUT_BYTES`, 5: inter-byte timeout in byte times. Timeout = `c_TIMEOUT_BYTES*10*c_CLKS_PER_BIT` clocks, default 86800.

Ports:
- `clk_100MHz`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_Rx_DV`  in  1  one-clock strobe: `i_Rx_Byte` is valid.
- `i_Rx_Byte`  in  8  received byte.
- `o_tics_per_rev`  out  16  encoder tics per revolution; reset 16'h0000.
- `o_speed1`  out  8  left set point, 0x00..0x7F reverse, 0x80..0xFF forward; reset 8'h80.
- `o_speed2`  out  8  right set point, same encoding; reset 8'h80.
- `o_accel`  out  8  acceleration; reset 8'h00.
- `o_get_enc1`  out  1  one-clock request for a left encoder report; reset 0.
- `o_get_enc2`  out  1  one-clock request for a right encoder report; reset 0.
- `o_rst_encdrs`  out  1  one-clock encoder-zero strobe; reset 0.
- `o_cmd_valid`  out  1  one-clock strobe per accepted frame; reset 0.
- `o_cmd_err`  out  1  one-clock strobe per rejected frame; reset 0.

## Operation
- Frame format: SOM 0x55, CMD, payload, CHK. CHK = XOR of CMD and all payload bytes.
- Payload length by command:
  - 0x11 (tics_per_rev): 2 bytes, high byte first.
  - 0x21 (set_speed1), 0x22 (set_speed2), 0x23 (set_accel): 1 byte.
  - 0x24 (get_encdr1), 0x25 (get_encdr2), 0x26 (rst_encdrs): 0 bytes.
- FSM states and transitions (all advances happen only on `i_Rx_DV`):
  - HUNT: a 0x55 byte moves to CMD. Any other byte is discarded silently.
  - CMD: a known code latches the command and its payload length, then goes to DATA, or to CHK if the length is 0. An unknown code raises `o_cmd_err` and returns to HUNT.
  - DATA: shifts in payload bytes into a 16-bit holding register, counting down the remaining length. After the last payload byte it goes to CHK.
  - CHK: a match commits the command and returns to HUNT. A mismatch raises `o_cmd_err` and returns to HUNT.
- Commit:
  - Write the targeted register.
  - Pulse the action strobe if the command has one.
  - Pulse `o_cmd_valid`.
  - Commit happens in the same cycle for all of these.
- No mid-frame resync: a 0x55 byte seen in CMD/DATA/CHK is treated as ordinary data.
- Output registers change only on commit. A partial or errored frame never modifies them.

## Timing
- Commit latency: registers and strobes update on the clock edge after the CHK byte's `i_Rx_DV` cycle, i.e. they are visible 1 clock later.
- All strobes are exactly 1 clock wide, and at most one `o_cmd_valid` or `o_cmd_err` fires per frame.
- Timeout:
  - The counter clears on every `i_Rx_DV`.
  - It runs while the FSM is outside HUNT.
  - On reaching the terminal count it raises `o_cmd_err` for 1 clock and returns to HUNT.
  - If `i_Rx_DV` arrives in the same cycle as terminal count, the byte wins: it is processed and the counter clears.
- Back-to-back frames: a SOM arriving on the first `i_Rx_DV` after commit is accepted. There is no dead time.
- Reset asserted mid-frame: the FSM goes to HUNT, all outputs take their reset values, and the timeout counter clears.

## Structure
- Package `uart_cmd_pkg` holds:
  - SOM and the seven command codes (shared with the future `uart_tx`-side responder);
  - the FSM state enum;
  - a payload-length lookup function.
- Sub-module `uart_rx_timeout`: a loadable down-counter with `clear`, `run` and `expired` ports, width derived with `$clog2`.
- Integrates in `top` behind the existing `uart_rx` instance (`w_Rx_DV`/`w_Rx_Byte`).

## Test plan
- Set speed 1: send 55 21 C0 E1 → `o_speed1`=0xC0 and one `o_cmd_valid` pulse; all other outputs unchanged.
- Set tics per rev: send 55 11 05 A0 B4 → `o_tics_per_rev`=0x05A0 and one `o_cmd_valid` pulse.
- Checksum error: send 55 22 10 00 → one `o_cmd_err` pulse, `o_speed2` stays 0x80. A following 55 26 26 → exactly one `o_rst_encdrs` pulse.
- Unknown command and leading noise:
  - Send 12 55 99 → one `o_cmd_err` pulse; the leading 12 is ignored.
  - Then send 55 24 24 → one `o_get_enc1` pulse.
- Timeout with DV/terminal-count collision:
  - Send 55 23, then idle for 86800 clocks → one `o_cmd_err` pulse and `o_accel` stays 0x00.
  - Repeat with a byte landing on the terminal-count cycle → no error; parsing continues.
- Reset mid-frame: send 55 11 05, pulse `rst_n` low, then send 55 25 25 → all outputs at reset values after the reset pulse, then one `o_get_enc2` pulse for the new frame.
